// File: rtl/gray2bin_pkg.sv
// Shared types and the Gray-to-binary reference function for the gray2bin arbiter.
// The function works on words up to G2B_W bits; callers zero-extend and truncate.
package gray2bin_pkg;
  typedef enum logic [1:0] {IDLE, CONV, RESP} state_e;

  localparam int G2B_W = 64;

  function automatic logic [G2B_W-1:0] gray_to_bin(input logic [G2B_W-1:0] g);
    logic [G2B_W-1:0] b;
    b = '0;
    b[G2B_W-1] = g[G2B_W-1];
    // Zero upper bits pass through, so the low bits are correct for any width.
    for (int k = G2B_W-2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin_core.sv
// Registered Gray-to-binary converter: combinational conversion, one load-enabled
// output register holding the binary result and the Gray echo (N <= 64).
module gray2bin_core
  import gray2bin_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o,
  output logic [N-1:0] gray_o
);
  logic [N-1:0] bin_d;
  logic [N-1:0] bin_q, gray_q;

  assign bin_d = N'(gray_to_bin(G2B_W'(gray_i)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else if (en_i) begin
      bin_q  <= bin_d;
      gray_q <= gray_i;
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
endmodule

// File: rtl/gray2bin_arb.sv
// Round-robin arbiter sharing one registered Gray-to-binary converter between
// NREQ requesters; one conversion in flight, result returned with requester ID.
module gray2bin_arb
  import gray2bin_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_gray,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_bin,
  output logic [N-1:0]      rsp_gray,
  output logic [ID_W-1:0]   rsp_id,
  output logic              busy,
  output logic [CNT_W-1:0]  conv_count
);
  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q, in_id_q, rsp_id_q, win_id;
  logic [N-1:0]      in_gray_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              win_vld;
  logic [ID_W:0]     idx;

  // Scan offsets high to low so the smallest offset from rr_ptr wins last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NREQ)) idx = idx - (ID_W+1)'(NREQ);
      if (req_valid[idx[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_vld) req_ready[win_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      in_id_q   <= '0;
      in_gray_q <= '0;
      rsp_id_q  <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (win_vld) begin
          in_gray_q <= req_gray[win_id*N +: N];
          in_id_q   <= win_id;
          rr_ptr_q  <= (win_id == ID_W'(NREQ-1)) ? '0 : win_id + 1'b1;
          state_q   <= CONV;
        end
        CONV: begin
          rsp_id_q <= in_id_q;
          state_q  <= RESP;
        end
        RESP: if (rsp_ready) begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  gray2bin_core #(.N(N)) u_core (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == CONV),
    .gray_i (in_gray_q),
    .bin_o  (rsp_bin),
    .gray_o (rsp_gray)
  );

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = rsp_id_q;
  assign conv_count = cnt_q;
endmodule

// File: tb/tb_gray2bin_arb.sv
// Bench for gray2bin_arb: scoreboard fed at grant time, table-driven sweep,
// plus directed back-pressure, fairness and mid-flight reset sequences.
module tb_gray2bin_arb;
  localparam int N = 3, NREQ = 4, CNT_W = 4, ID_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_gray;
  logic              rsp_valid, rsp_ready, busy;
  logic [N-1:0]      rsp_bin, rsp_gray;
  logic [ID_W-1:0]   rsp_id;
  logic [CNT_W-1:0]  conv_count;

  always #5 clk = ~clk;

  gray2bin_arb #(.N(N), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_gray(req_gray),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bin(rsp_bin), .rsp_gray(rsp_gray), .rsp_id(rsp_id), .busy(busy),
    .conv_count(conv_count)
  );

  typedef struct { int id; logic [N-1:0] gray; logic [N-1:0] bin; } exp_t;

  exp_t            exp_q[$];
  int              grants[$];
  exp_t            tbl[16];
  logic [N-1:0]    exp_bin_c [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd7, 3'd6, 3'd4, 3'd5};
  int              cyc, n_chk, n_fail, first_grant_cyc, last_rsp_cyc, r_id;
  logic [NREQ-1:0] sticky, s_ready;
  logic            s_rvalid, s_busy, rsp_seen;
  logic [N-1:0]    s_bin, s_gray, r_bin;
  logic [ID_W-1:0] s_id;
  logic [CNT_W-1:0] s_cnt;

  function automatic logic [N-1:0] ref_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = g;
    for (int s = 1; s < N; s++) b ^= g >> s;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: sample just before the posedge, log handshakes, advance to negedge.
  task automatic tick();
    logic [NREQ-1:0] hs;
    exp_t e;
    hs = '0;
    #1;
    s_ready = req_ready; s_rvalid = rsp_valid; s_busy = busy;
    s_bin = rsp_bin; s_gray = rsp_gray; s_id = rsp_id; s_cnt = conv_count;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    chk("ready_needs_valid", 32'(req_ready & ~req_valid), 0);
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        hs[i] = 1'b1;
        if (grants.size() == 0) first_grant_cyc = cyc;
        grants.push_back(i);
        exp_q.push_back('{i, req_gray[i*N +: N], ref_bin(req_gray[i*N +: N])});
      end
    if (rsp_valid && rsp_ready) begin
      rsp_seen = 1'b1; r_bin = rsp_bin; r_id = int'(rsp_id); last_rsp_cyc = cyc;
      if (exp_q.size() == 0) chk("rsp_with_empty_sb", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("sb_id", 32'(rsp_id), 32'(e.id));
        chk("sb_gray", 32'(rsp_gray), 32'(e.gray));
        chk("sb_bin", 32'(rsp_bin), 32'(e.bin));
      end
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++) if (hs[i] && !sticky[i]) req_valid[i] = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 60 && !done; t++) begin
      if (exp_q.size() == 0 && req_valid == '0 && !busy) done = 1'b1;
      else tick();
    end
    chk({nm, "_drain"}, 32'(exp_q.size()) + 32'(busy) + 32'(req_valid), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; sticky = '0; rsp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    exp_q.delete(); grants.delete();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    n_chk = 0; n_fail = 0; cyc = 0; rsp_seen = 1'b0; r_id = 0; r_bin = '0;
    first_grant_cyc = 0; last_rsp_cyc = 0;
    for (int k = 0; k < 16; k++) tbl[k] = '{k % 4, N'(k % 8), exp_bin_c[k % 8]};
    reset = 1'b1; req_valid = '0; req_gray = '0; rsp_ready = 1'b0; sticky = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_bin", 32'(rsp_bin), 0);
    chk("rst_rsp_gray", 32'(rsp_gray), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(conv_count), 0);
    @(negedge clk); reset = 1'b0;

    // single request from requester 2
    req_gray[2*N +: N] = 3'b101; req_valid[2] = 1'b1; rsp_ready = 1'b1;
    tick(); chk("t1_grant", 32'(s_ready), 4'b0100);
    tick(); chk("t1_conv_busy", 32'(s_busy), 1); chk("t1_conv_nvld", 32'(s_rvalid), 0);
    chk("t1_conv_nready", 32'(s_ready), 0);
    tick(); chk("t1_rsp_valid", 32'(s_rvalid), 1); chk("t1_bin", 32'(s_bin), 3'b110);
    chk("t1_id", 32'(s_id), 2); chk("t1_gray", 32'(s_gray), 3'b101);
    tick(); chk("t1_count", 32'(s_cnt), 1); chk("t1_idle", 32'(s_busy), 0);

    // all four at once, ordered 0..3 from a fresh pointer
    do_reset();
    req_gray = {3'b100, 3'b111, 3'b110, 3'b001}; req_valid = 4'hF; rsp_ready = 1'b1;
    drain("t2");
    chk("t2_ngrants", 32'(grants.size()), 4);
    for (int k = 0; k < 4; k++) chk("t2_order", grants.size() > k ? grants[k] : -1, k);
    chk("t2_count", 32'(conv_count), 4);
    chk("t2_throughput", last_rsp_cyc - first_grant_cyc, 11);

    // back-pressure with a competing requester pending
    req_gray[1*N +: N] = 3'b010; req_valid[1] = 1'b1; rsp_ready = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin tick(); got = s_rvalid; end
    chk("t3_reach_resp", 32'(got), 1);
    req_gray[0 +: N] = 3'b011; req_valid[0] = 1'b1;
    repeat (5) begin
      tick();
      chk("t3_hold_valid", 32'(s_rvalid), 1); chk("t3_hold_bin", 32'(s_bin), 3'b011);
      chk("t3_hold_noready", 32'(s_ready), 0);
    end
    rsp_ready = 1'b1;
    tick(); chk("t3_handshake", 32'(s_rvalid), 1);
    tick(); chk("t3_vld_fall", 32'(s_rvalid), 0); chk("t3_idle", 32'(s_busy), 0);
    chk("t3_next_grant", 32'(s_ready), 4'b0001);
    drain("t3");

    // fairness between requesters 0 and 3 across the pointer wrap
    do_reset();
    req_gray[0 +: N] = 3'b000; req_gray[3*N +: N] = 3'b111;
    sticky = 4'b1001; req_valid = 4'b1001; rsp_ready = 1'b1;
    for (int t = 0; t < 40 && grants.size() < 4; t++) tick();
    sticky = '0;
    drain("t4");
    for (int k = 0; k < 4; k++)
      chk("t4_alternate", grants.size() > k ? grants[k] : -1, (k % 2) ? 3 : 0);

    // reset while a conversion is in CONV
    do_reset();
    rsp_ready = 1'b1; req_gray[2*N +: N] = 3'b111; req_valid[2] = 1'b1;
    tick(); chk("t5_grant", 32'(s_ready), 4'b0100);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_busy", 32'(busy), 0); chk("t5_async_bin", 32'(rsp_bin), 0);
    chk("t5_async_gray", 32'(rsp_gray), 0); chk("t5_async_id", 32'(rsp_id), 0);
    chk("t5_async_vld", 32'(rsp_valid), 0);
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    repeat (6) begin tick(); chk("t5_no_rsp", 32'(s_rvalid), 0); end
    req_gray[1*N +: N] = 3'b011; req_valid[1] = 1'b1;
    drain("t5");
    chk("t5_bin", 32'(r_bin), 3'b010); chk("t5_id", r_id, 1);
    chk("t5_count", 32'(conv_count), 1);

    // table sweep: every Gray code twice, counter wraps after 16
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req_gray[tbl[k].id*N +: N] = tbl[k].gray; req_valid[tbl[k].id] = 1'b1;
      rsp_seen = 1'b0;
      for (int t = 0; t < 10 && !rsp_seen; t++) tick();
      chk("t6_rsp_seen", 32'(rsp_seen), 1);
      chk("t6_bin", 32'(r_bin), 32'(tbl[k].bin));
      chk("t6_id", r_id, tbl[k].id);
    end
    chk("t6_count_wrap", 32'(conv_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
